// File: rtl/serout_pkg.sv
// Shared types, parameter limits and frame-length helper for the buffered serial transmitter.
package serout_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DATA_W_MIN    = 5;
    localparam int unsigned DATA_W_MAX    = 9;
    localparam int unsigned STOP_BITS_MIN = 1;
    localparam int unsigned STOP_BITS_MAX = 2;

    // Start bit + data + optional parity + stop bits.
    function automatic int unsigned frame_len(int unsigned data_w,
                                              int unsigned parity_en,
                                              int unsigned stop_bits);
        return 1 + data_w + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/serout_tx_buffered_if.sv
// Host-side write/strobe bus and serial/status outputs of the buffered transmitter.
interface serout_tx_buffered_if #(
    parameter int unsigned DATA_W = 8
);
    logic              bit_tick;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              force_break;
    logic              ser_out;
    logic              holder_empty;
    logic              tx_idle;
    logic              frame_done;
    logic              overrun;

    modport master (
        output bit_tick, wr_en, wr_data, force_break,
        input  ser_out, holder_empty, tx_idle, frame_done, overrun
    );

    modport slave (
        input  bit_tick, wr_en, wr_data, force_break,
        output ser_out, holder_empty, tx_idle, frame_done, overrun
    );
endinterface

// File: rtl/serout_frame_builder.sv
// Combinational frame assembly: start bit, ordered data, optional parity, stop bits.
module serout_frame_builder
    import serout_pkg::*;
#(
    parameter  int unsigned DATA_W     = 8,
    parameter  int unsigned PARITY_EN  = 0,
    parameter  int unsigned PARITY_ODD = 0,
    parameter  int unsigned STOP_BITS  = 1,
    parameter  int unsigned LSB_FIRST  = 1,
    localparam int unsigned N          = frame_len(DATA_W, PARITY_EN, STOP_BITS)
) (
    input  logic [DATA_W-1:0] data,
    output logic [N-1:0]      frame
);

    logic [DATA_W-1:0] ordered;
    logic              parity;

    for (genvar i = 0; i < DATA_W; i++) begin : g_order
        assign ordered[i] = (LSB_FIRST != 0) ? data[i] : data[DATA_W-1-i];
    end

    assign parity = (^data) ^ (PARITY_ODD != 0);

    // Frame bit 0 goes out first; everything above the data/parity is stop (mark).
    always_comb begin
        frame            = '1;
        frame[DATA_W:0]  = {ordered, 1'b0};
        if (PARITY_EN != 0) begin
            frame[DATA_W+1] = parity;
        end
    end

endmodule

// File: rtl/serout_tx_buffered.sv
// Serial transmitter with a one-deep holding register, back-to-back frames and break control.
module serout_tx_buffered
    import serout_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned LSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    serout_tx_buffered_if.slave  bus
);

    localparam int unsigned N     = frame_len(DATA_W, PARITY_EN, STOP_BITS);
    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $fatal(1, "serout_tx_buffered: DATA_W must be 5..9");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
        $fatal(1, "serout_tx_buffered: STOP_BITS must be 1 or 2");
    end
    if (PARITY_EN > 1 || PARITY_ODD > 1 || LSB_FIRST > 1) begin : g_bad_flag
        $fatal(1, "serout_tx_buffered: PARITY_EN/PARITY_ODD/LSB_FIRST must be 0 or 1");
    end

    state_t            state, state_nx;
    logic [DATA_W-1:0] holder, holder_nx;
    logic              full, full_nx;
    logic [N-1:0]      shifter, shifter_nx, frame;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              load, line_nx, done_nx, ovr_nx;
    logic              ser_q, empty_q, idle_q, done_q, ovr_q;

    serout_frame_builder #(
        .DATA_W     (DATA_W),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD),
        .STOP_BITS  (STOP_BITS),
        .LSB_FIRST  (LSB_FIRST)
    ) u_builder (
        .data  (holder),
        .frame (frame)
    );

    always_comb begin
        state_nx   = state;
        holder_nx  = holder;
        full_nx    = full;
        shifter_nx = shifter;
        cnt_nx     = cnt;
        load       = 1'b0;
        done_nx    = 1'b0;
        ovr_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (full) load = 1'b1;
            end
            SHIFT: begin
                if (bus.bit_tick) begin
                    if (cnt == LAST) begin
                        if (full) begin
                            load = 1'b1;
                        end else begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                            done_nx  = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (load) begin
            state_nx   = SHIFT;
            shifter_nx = frame;
            cnt_nx     = '0;
            full_nx    = 1'b0;
        end

        // A write on a transfer edge refills the holder the shifter just drained.
        if (bus.wr_en) begin
            holder_nx = bus.wr_data;
            full_nx   = 1'b1;
            ovr_nx    = full && !load;
        end

        line_nx = (state_nx == SHIFT) ? shifter_nx[cnt_nx] : 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            holder  <= '0;
            full    <= 1'b0;
            shifter <= '0;
            cnt     <= '0;
            ser_q   <= 1'b1;
            empty_q <= 1'b1;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            holder  <= holder_nx;
            full    <= full_nx;
            shifter <= shifter_nx;
            cnt     <= cnt_nx;
            ser_q   <= bus.force_break ? 1'b0 : line_nx;
            empty_q <= !full_nx;
            idle_q  <= (state_nx == IDLE) && !full_nx;
            done_q  <= done_nx;
            ovr_q   <= ovr_nx;
        end
    end

    assign bus.ser_out      = ser_q;
    assign bus.holder_empty = empty_q;
    assign bus.tx_idle      = idle_q;
    assign bus.frame_done   = done_q;
    assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_serout_tx_buffered.sv
// Directed bench: default 8N1 instance plus a 7-bit, odd-parity, 2-stop, MSB-first instance.
module tb_serout_tx_buffered;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic       brk;
    logic       wr_en_a, wr_en_b;
    logic [7:0] wr_data_a;
    logic [6:0] wr_data_b;
    int         n_vec;
    int         n_err;

    localparam logic [15:0] F_A5 = 16'b1101001010;
    localparam logic [15:0] F_11 = 16'b1000100010;
    localparam logic [15:0] F_22 = 16'b1001000100;
    localparam logic [15:0] F_0F = 16'b1000011110;
    localparam logic [15:0] F_55 = 16'b1010101010;
    localparam logic [15:0] F_FF = 16'b1111111110;
    localparam logic [15:0] F_00 = 16'b1000000000;
    localparam logic [15:0] FB_03 = 16'b11111000000;
    localparam logic [15:0] FB_01 = 16'b11010000000;

    serout_tx_buffered_if #(.DATA_W(8)) ifa ();
    serout_tx_buffered_if #(.DATA_W(7)) ifb ();

    assign ifa.bit_tick    = tick;
    assign ifa.force_break = brk;
    assign ifa.wr_en       = wr_en_a;
    assign ifa.wr_data     = wr_data_a;
    assign ifb.bit_tick    = tick;
    assign ifb.force_break = brk;
    assign ifb.wr_en       = wr_en_b;
    assign ifb.wr_data     = wr_data_b;

    serout_tx_buffered #(.DATA_W(8)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa.slave)
    );

    serout_tx_buffered #(
        .DATA_W     (7),
        .PARITY_EN  (1),
        .PARITY_ODD (1),
        .STOP_BITS  (2),
        .LSB_FIRST  (0)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ser(int sel);
        return (sel != 0) ? ifb.ser_out : ifa.ser_out;
    endfunction
    function automatic logic done(int sel);
        return (sel != 0) ? ifb.frame_done : ifa.frame_done;
    endfunction
    function automatic logic idle(int sel);
        return (sel != 0) ? ifb.tx_idle : ifa.tx_idle;
    endfunction
    function automatic logic hempty(int sel);
        return (sel != 0) ? ifb.holder_empty : ifa.holder_empty;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic bit_period();
        tick = 1'b0;
        repeat (3) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic write(input int sel, input logic [7:0] d);
        if (sel != 0) begin
            wr_en_b   = 1'b1;
            wr_data_b = d[6:0];
        end else begin
            wr_en_a   = 1'b1;
            wr_data_a = d;
        end
        @(negedge clk);
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    // Ticks through frame bits [from, to) checking the line and that no completion fires.
    task automatic bits(input int sel, input logic [15:0] exp, input int from, input int to,
                        input string tag);
        logic [15:0] sh;
        for (int i = from; i < to; i++) begin
            bit_period();
            sh = exp >> i;
            check({tag, "_bit"}, ser(sel), sh[0]);
            check({tag, "_nodone"}, done(sel), 1'b0);
        end
    endtask

    task automatic end_idle(input int sel, input string tag);
        bit_period();
        check({tag, "_done"}, done(sel), 1'b1);
        check({tag, "_idle"}, idle(sel), 1'b1);
        check({tag, "_mark"}, ser(sel), 1'b1);
        @(negedge clk);
        check({tag, "_done_once"}, done(sel), 1'b0);
    endtask

    task automatic single_frame(input int sel, input logic [7:0] d, input logic [15:0] exp,
                                input int n, input string tag);
        write(sel, d);
        check({tag, "_full"}, hempty(sel), 1'b0);
        check({tag, "_wait"}, ser(sel), 1'b1);
        @(negedge clk);
        check({tag, "_start"}, ser(sel), exp[0]);
        check({tag, "_xfer"}, hempty(sel), 1'b1);
        check({tag, "_busy"}, idle(sel), 1'b0);
        bits(sel, exp, 1, n, tag);
        end_idle(sel, tag);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        tick      = 1'b0;
        brk       = 1'b0;
        wr_en_a   = 1'b0;
        wr_en_b   = 1'b0;
        wr_data_a = '0;
        wr_data_b = '0;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ser", ser(s), 1'b1);
            check("rst_hempty", hempty(s), 1'b1);
            check("rst_idle", idle(s), 1'b1);
            check("rst_done", done(s), 1'b0);
        end
        check("rst_ovr", ifa.overrun, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // 8N1 frame, then the 7O2 MSB-first instance with both parity outcomes.
        single_frame(0, 8'hA5, F_A5, 10, "a5");
        single_frame(1, 8'h03, FB_03, 11, "b03");
        single_frame(1, 8'h01, FB_01, 11, "b01");

        // Second write during a frame chains with no idle gap.
        write(0, 8'h11);
        @(negedge clk);
        check("chain_start1", ser(0), 1'b0);
        bits(0, F_11, 1, 4, "chain1");
        write(0, 8'h22);
        check("chain_hold", hempty(0), 1'b0);
        check("chain_noovr", ifa.overrun, 1'b0);
        bits(0, F_11, 4, 10, "chain1b");
        bit_period();
        check("chain_start2", ser(0), 1'b0);
        check("chain_nodone", done(0), 1'b0);
        check("chain_drained", hempty(0), 1'b1);
        check("chain_busy", idle(0), 1'b0);
        bits(0, F_22, 1, 10, "chain2");
        end_idle(0, "chain2");

        // Write on the transfer edge is not an overrun; later writes are.
        write(0, 8'h0F);
        write(0, 8'h33);
        check("ovr_xfer_edge", ifa.overrun, 1'b0);
        check("ovr_hold", hempty(0), 1'b0);
        check("ovr_start", ser(0), 1'b0);
        write(0, 8'h44);
        check("ovr_pulse1", ifa.overrun, 1'b1);
        write(0, 8'h55);
        check("ovr_pulse2", ifa.overrun, 1'b1);
        @(negedge clk);
        check("ovr_clear", ifa.overrun, 1'b0);
        bits(0, F_0F, 1, 10, "ovr0f");
        bit_period();
        check("ovr_next_start", ser(0), 1'b0);
        check("ovr_next_nodone", done(0), 1'b0);
        bits(0, F_55, 1, 10, "ovr55");
        end_idle(0, "ovr55");

        // Break for three ticks mid-frame; tick count to frame end unchanged.
        write(0, 8'hFF);
        @(negedge clk);
        check("brk_start", ser(0), 1'b0);
        bits(0, F_FF, 1, 3, "brk_pre");
        brk = 1'b1;
        @(negedge clk);
        check("brk_on", ser(0), 1'b0);
        repeat (3) begin
            bit_period();
            check("brk_held", ser(0), 1'b0);
            check("brk_nodone", done(0), 1'b0);
        end
        brk = 1'b0;
        @(negedge clk);
        check("brk_release", ser(0), 1'b1);
        bits(0, F_FF, 6, 10, "brk_post");
        end_idle(0, "brk");

        // Asynchronous reset mid-frame with a byte waiting in the holder.
        write(0, 8'h00);
        @(negedge clk);
        check("rmid_start", ser(0), 1'b0);
        bits(0, F_00, 1, 3, "rmid");
        write(0, 8'h5A);
        check("rmid_full", hempty(0), 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rmid_ser", ser(0), 1'b1);
        check("rmid_hempty", hempty(0), 1'b1);
        check("rmid_idle", idle(0), 1'b1);
        check("rmid_done", done(0), 1'b0);
        check("rmid_ovr", ifa.overrun, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick = (k % 4 == 3);
            @(negedge clk);
            check("post_rst_ser", ser(0), 1'b1);
            check("post_rst_idle", idle(0), 1'b1);
            check("post_rst_nodone", done(0), 1'b0);
        end
        tick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
